csr_access_unit: RTL

Sequencer between the pipeline's CSR instruction path and the CSR register bank (mstatus and peers). It accepts one CSRRW/CSRRS/CSRRC request at a time and performs a read probe, then an optional write. The write is expressed as per-bit set/clear masks on the shared `csr_en_o`/`csr_addr_o`/`csr_set_o`/`csr_clear_o` bus that every CSR register decodes. It returns the old CSR value, or an illegal-instruction flag when no register acknowledges or a read-only CSR is written.

---
 rtl/csr_access_unit.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/csr_access_unit.sv
// ============================================================================
// Module   : csr_access_unit
// Purpose  : Sequences one CSRRW/CSRRS/CSRRC at a time: read probe, optional
//            set/clear-mask write on the shared CSR bus, then response.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module csr_access_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_op_i,
    input  logic [11:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic        req_rs_nz_i,
    output logic        csr_en_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_set_o,
    output logic [31:0] csr_clear_o,
    input  logic        csr_ack_i,
    input  logic [31:0] csr_rdata_i,
    input  logic        flush_i,
    output logic        resp_valid_o,
    input  logic        resp_ready_i,
    output logic [31:0] resp_rdata_o,
    output logic        resp_illegal_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_RESP  = 2'd3
    } state_e;

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_RW  = 2'b01;
    localparam logic [1:0] OP_RS  = 2'b10;
    localparam logic [1:0] OP_RC  = 2'b11;

    state_e      state_q,   state_d;
    logic [1:0]  op_q,      op_d;
    logic [11:0] addr_q,    addr_d;
    logic [31:0] wdata_q,   wdata_d;
    logic        rs_nz_q,   rs_nz_d;
    logic [31:0] rdata_q,   rdata_d;
    logic        illegal_q, illegal_d;
    logic        we;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            op_q      <= OP_ILL;
            addr_q    <= 12'd0;
            wdata_q   <= 32'd0;
            rs_nz_q   <= 1'b0;
            rdata_q   <= 32'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rs_nz_q   <= rs_nz_d;
            rdata_q   <= rdata_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rs_nz_d     = rs_nz_q;
        rdata_d     = rdata_q;
        illegal_d   = illegal_q;
        req_ready_o = 1'b0;
        csr_en_o    = 1'b0;
        csr_set_o   = 32'd0;
        csr_clear_o = 32'd0;
        resp_valid_o = 1'b0;
        // RS/RC with a zero source operand are pure reads
        we          = (op_q == OP_RW) || rs_nz_q;

        case (state_q)
            S_IDLE: begin
                req_ready_o = !flush_i;
                if (req_valid_i && !flush_i) begin
                    op_d      = req_op_i;
                    addr_d    = req_addr_i;
                    wdata_d   = req_wdata_i;
                    rs_nz_d   = req_rs_nz_i;
                    rdata_d   = 32'd0;
                    illegal_d = (req_op_i == OP_ILL);
                    state_d   = (req_op_i == OP_ILL) ? S_RESP : S_READ;
                end
            end
            S_READ: begin
                csr_en_o = 1'b1;
                if (flush_i) begin
                    state_d = S_IDLE;
                end else if (!csr_ack_i || (we && addr_q[11:10] == 2'b11)) begin
                    illegal_d = 1'b1;
                    rdata_d   = 32'd0;
                    state_d   = S_RESP;
                end else begin
                    illegal_d = 1'b0;
                    rdata_d   = csr_rdata_i;
                    state_d   = we ? S_WRITE : S_RESP;
                end
            end
            S_WRITE: begin
                // Strobe is driven even when flushed so the write still commits
                csr_en_o = 1'b1;
                case (op_q)
                    OP_RW: begin
                        csr_set_o   = wdata_q;
                        csr_clear_o = ~wdata_q;
                    end
                    OP_RS:   csr_set_o   = wdata_q;
                    OP_RC:   csr_clear_o = wdata_q;
                    default: ;
                endcase
                state_d = flush_i ? S_IDLE : S_RESP;
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
                if (flush_i || resp_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign csr_addr_o     = addr_q;
    assign resp_rdata_o   = rdata_q;
    assign resp_illegal_o = illegal_q;

endmodule

`default_nettype wire
